// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Imported by the divider top and its step datapath.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CW_DEF = $clog2(DW_DEF);

  // A one-bit dividend still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW-1:0] rem,
  input  logic          dbit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_next,
  output logic          qbit
);

  logic [VW:0] t;
  logic [VW:0] d;

  assign t    = {rem, dbit};
  assign d    = {1'b0, divisor};
  assign qbit = (t >= d);

  // Low VW bits of t-d are exact: the true difference is < divisor.
  assign rem_next = qbit ? (t[VW-1:0] - divisor)
                         : t[VW-1:0];

endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider, one quotient bit per
// cycle, with valid/ready handshakes on both sides.
module seq_restoring_div
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = cnt_width(DW);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic          dz;
  logic [VW-1:0] rem;
  logic [DW-1:0] quo;

  logic [VW-1:0] rem_n;
  logic          qbit;
  logic [DW:0]   dvd_x;
  logic [DW:0]   quo_x;
  logic          accept;
  logic          last;

  div_step #(
    .VW(VW)
  ) u_step (
    .rem      (rem),
    .dbit     (dvd[DW-1]),
    .divisor  (dvs),
    .rem_next (rem_n),
    .qbit     (qbit)
  );

  assign dvd_x = {dvd, 1'b0};
  assign quo_x = {quo, qbit};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;
  assign last      = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid)  state_n = BUSY;
      BUSY: if (cnt == '0) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      dz          <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        dvd <= dividend;
        dvs <= divisor;
        dz  <= (divisor == '0);
        rem <= '0;
        quo <= '0;
        cnt <= CW'(DW - 1);
      end
      if (state == BUSY) begin
        rem <= rem_n;
        dvd <= dvd_x[DW-1:0];
        quo <= quo_x[DW-1:0];
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      // Results only move on the final step, so DONE holds them.
      if (last) begin
        quotient    <= dz ? '1 : quo_x[DW-1:0];
        remainder   <= dz ? '0 : rem_n;
        div_by_zero <= dz;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed and exhaustive checks of seq_restoring_div with
// hand-computed results, latency, backpressure and reset.
module tb_seq_restoring_div;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int vecs;
  int errs;

  seq_restoring_div #(
    .DW(8),
    .VW(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accept one operand pair, wait for the result, stall, retire it.
  task automatic run(
    input  logic [7:0] a,
    input  logic [3:0] b,
    input  int         stall,
    output logic [7:0] q,
    output logic [3:0] r,
    output logic       z,
    output int         lat
  );
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
    repeat (stall) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero}
        !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
      errs++;
      $display("FAIL reset: rdy=%b vld=%b q=%0d r=%0d dz=%b want 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    logic [7:0] ta [4];
    logic [3:0] tb [4];
    logic [7:0] tq [4];
    logic [3:0] tr [4];
    ta = '{8'd200, 8'd255, 8'd5, 8'd0};
    tb = '{4'd7, 4'd15, 4'd9, 4'd1};
    tq = '{8'd28, 8'd17, 8'd0, 8'd0};
    tr = '{4'd4, 4'd0, 4'd5, 4'd0};
    for (int i = 0; i < 4; i++) begin
      run(ta[i], tb[i], 0, q, r, z, lat);
      vecs++;
      if ({q, r, z} !== {tq[i], tr[i], 1'b0}) begin
        errs++;
        $display("FAIL basic %0d/%0d: got q=%0d r=%0d dz=%b want %0d %0d 0",
                 ta[i], tb[i], q, r, z, tq[i], tr[i]);
      end
      vecs++;
      if (lat !== 9) begin
        errs++;
        $display("FAIL latency %0d/%0d: got %0d want 9", ta[i], tb[i], lat);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    run(8'd13, 4'd0, 0, q, r, z, lat);
    vecs++;
    if ({q, r, z} !== {8'd255, 4'd0, 1'b1}) begin
      errs++;
      $display("FAIL div_zero: got q=%0d r=%0d dz=%b want 255 0 1", q, r, z);
    end
    vecs++;
    if (lat !== 9) begin
      errs++;
      $display("FAIL div_zero_latency: got %0d want 9", lat);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    @(negedge clk);
    dividend  = 8'd50;
    divisor   = 4'd6;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    dividend = 8'd99;
    divisor  = 4'd2;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if ({out_valid, in_ready, quotient, remainder, div_by_zero}
          !== {1'b1, 1'b0, 8'd8, 4'd2, 1'b0}) bad++;
      @(posedge clk);
      #1;
    end
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL backpressure: %0d unstable cycles, now vld=%b rdy=%b q=%0d r=%0d want 1 0 8 2",
               bad, out_valid, in_ready, quotient, remainder);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL bp_release: rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    int         seen;
    @(negedge clk);
    dividend = 8'd77;
    divisor  = 4'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vecs++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL reset_mid: rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    vecs++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL reset_mid_pulse: %0d out_valid cycles want 0", seen);
    end
    run(8'd100, 4'd3, 0, q, r, z, lat);
    vecs++;
    if ({q, r, z, lat} !== {8'd33, 4'd1, 1'b0, 32'd9}) begin
      errs++;
      $display("FAIL after_reset 100/3: got q=%0d r=%0d dz=%b lat=%0d want 33 1 0 9",
               q, r, z, lat);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    dividend  = 8'd20;
    divisor   = 4'd3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 40);
    vecs++;
    if ({n, quotient, remainder} !== {32'd10, 8'd6, 4'd2}) begin
      errs++;
      $display("FAIL back_to_back: period=%0d q=%0d r=%0d want 10 6 2",
               n, quotient, remainder);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    int         stall;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        stall = $urandom_range(0, 2);
        run(a[7:0], b[3:0], stall, q, r, z, lat);
        if (b == 0) begin
          eq = 8'hff;
          er = 4'd0;
          ez = 1'b1;
        end else begin
          eq = 8'(a / b);
          er = 4'(a % b);
          ez = 1'b0;
        end
        vecs++;
        if ({q, r, z, lat} !== {eq, er, ez, 32'd9}) begin
          errs++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%b lat=%0d want %0d %0d %b 9",
                   a, b, q, r, z, lat, eq, er, ez);
        end
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
